// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: DEPTH stages with valid bits, stall/flush and register-file forwarding.
// Optional build macro MEM_WB_PERF_EN adds saturating stall_cnt / flush_cnt counters.
module mem_wb_pipe_reg #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [DSIZE-1:0] alu_result_in,
  input  logic [DSIZE-1:0] mem_data_in,
  input  logic             memToReg_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             WriteEn_in,
  input  logic [ASIZE-1:0] rs_addr,
  input  logic [ASIZE-1:0] rt_addr,
  output logic             valid_out,
  output logic [DSIZE-1:0] alu_result_out,
  output logic [DSIZE-1:0] mem_data_out,
  output logic             memToReg_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             WriteEn_out,
  output logic [DSIZE-1:0] wb_data_out,
  output logic             fwd_rs_hit,
  output logic [DSIZE-1:0] fwd_rs_data,
  output logic             fwd_rt_hit,
  output logic [DSIZE-1:0] fwd_rt_data
`ifdef MEM_WB_PERF_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_err
      $fatal(1, "mem_wb_pipe_reg: DEPTH must be in 1..4");
    end
  endgenerate

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] m2r_r;
  logic [DEPTH-1:0] wen_r;
  logic [DSIZE-1:0] alu_r   [DEPTH];
  logic [DSIZE-1:0] mem_r   [DEPTH];
  logic [ASIZE-1:0] waddr_r [DEPTH];
  logic [DEPTH-1:0] act_s;

  function automatic logic [DSIZE-1:0] wb_sel(input logic m2r, input logic [DSIZE-1:0] mem,
                                              input logic [DSIZE-1:0] alu);
    return m2r ? mem : alu;
  endfunction

  // Stage registers: flush squashes valid/WriteEn only, stall holds, otherwise shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {DEPTH{1'b0}};
      m2r_r   <= {DEPTH{1'b0}};
      wen_r   <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        alu_r[i]   <= {DSIZE{1'b0}};
        mem_r[i]   <= {DSIZE{1'b0}};
        waddr_r[i] <= {ASIZE{1'b0}};
      end
    end else if (flush) begin
      valid_r <= {DEPTH{1'b0}};
      wen_r   <= {DEPTH{1'b0}};
    end else if (!stall) begin
      valid_r[0] <= valid_in;
      m2r_r[0]   <= memToReg_in;
      wen_r[0]   <= WriteEn_in;
      alu_r[0]   <= alu_result_in;
      mem_r[0]   <= mem_data_in;
      waddr_r[0] <= waddr_in;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        m2r_r[i]   <= m2r_r[i-1];
        wen_r[i]   <= wen_r[i-1];
        alu_r[i]   <= alu_r[i-1];
        mem_r[i]   <= mem_r[i-1];
        waddr_r[i] <= waddr_r[i-1];
      end
    end
  end

  // Per-stage write-active term; register 0 is never a write target.
  always_comb begin
    act_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      act_s[i] = valid_r[i] & wen_r[i] & (waddr_r[i] != {ASIZE{1'b0}});
    end
  end

  // Forwarding lookup: scan oldest to youngest so the youngest hit overwrites.
  always_comb begin
    fwd_rs_hit  = 1'b0;
    fwd_rs_data = {DSIZE{1'b0}};
    fwd_rt_hit  = 1'b0;
    fwd_rt_data = {DSIZE{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      fwd_rs_data = (act_s[i] && (waddr_r[i] == rs_addr)) ? wb_sel(m2r_r[i], mem_r[i], alu_r[i])
                                                          : fwd_rs_data;
      fwd_rs_hit  = fwd_rs_hit | (act_s[i] & (waddr_r[i] == rs_addr));
      fwd_rt_data = (act_s[i] && (waddr_r[i] == rt_addr)) ? wb_sel(m2r_r[i], mem_r[i], alu_r[i])
                                                          : fwd_rt_data;
      fwd_rt_hit  = fwd_rt_hit | (act_s[i] & (waddr_r[i] == rt_addr));
    end
  end

  assign valid_out      = valid_r[DEPTH-1];
  assign alu_result_out = alu_r[DEPTH-1];
  assign mem_data_out   = mem_r[DEPTH-1];
  assign memToReg_out   = m2r_r[DEPTH-1];
  assign waddr_out      = waddr_r[DEPTH-1];
  assign WriteEn_out    = act_s[DEPTH-1];
  assign wb_data_out    = wb_sel(m2r_r[DEPTH-1], mem_r[DEPTH-1], alu_r[DEPTH-1]);

`ifdef MEM_WB_PERF_EN
  // Saturating event counters; a flush edge counts as flush, never as stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (flush && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'h0001;
      end
      if (stall && !flush && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg (DEPTH=3): directed vector table, reset sequence,
// randomized run against an entry-list model, and perf counters when MEM_WB_PERF_EN is defined.
module tb_mem_wb_pipe_reg;

  logic        clk, rst, stall, flush, valid_in, memToReg_in, WriteEn_in;
  logic [15:0] alu_result_in, mem_data_in;
  logic [3:0]  waddr_in, rs_addr, rt_addr;
  logic        valid_out, memToReg_out, WriteEn_out, fwd_rs_hit, fwd_rt_hit;
  logic [15:0] alu_result_out, mem_data_out, wb_data_out, fwd_rs_data, fwd_rt_data;
  logic [3:0]  waddr_out;
`ifdef MEM_WB_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_pipe_reg #(.DSIZE(16), .ASIZE(4), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .mem_data_in(mem_data_in), .memToReg_in(memToReg_in),
    .waddr_in(waddr_in), .WriteEn_in(WriteEn_in), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .valid_out(valid_out), .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
    .memToReg_out(memToReg_out), .waddr_out(waddr_out), .WriteEn_out(WriteEn_out),
    .wb_data_out(wb_data_out), .fwd_rs_hit(fwd_rs_hit), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_hit(fwd_rt_hit), .fwd_rt_data(fwd_rt_data)
`ifdef MEM_WB_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic stall, flush, v, we, m2r;
    logic [3:0] wa, rs, rt;
    logic [15:0] alu, mem;
    logic e_vo, e_we;
    logic [3:0] e_wa;
    logic [15:0] e_wb;
    logic e_rsh;
    logic [15:0] e_rsd;
    logic e_rth;
    logic [15:0] e_rtd;
  } vec_t;

  typedef struct {
    logic v, we, m2r;
    logic [3:0] wa;
    logic [15:0] alu, mem;
  } ent_t;

  vec_t tbl [13];
  ent_t m [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic we,
                       input logic m2r, input logic [3:0] wa, input logic [15:0] alu,
                       input logic [15:0] mem, input logic [3:0] rs, input logic [3:0] rt);
    stall = st; flush = fl; valid_in = v; WriteEn_in = we; memToReg_in = m2r;
    waddr_in = wa; alu_result_in = alu; mem_data_in = mem; rs_addr = rs; rt_addr = rt;
  endtask

  function automatic logic active(input ent_t e);
    return e.v && e.we && (e.wa != 4'd0);
  endfunction

  function automatic logic [15:0] value(input ent_t e);
    return e.m2r ? e.mem : e.alu;
  endfunction

  // Model lookup: first (youngest) entry in the list writing q.
  task automatic model_fwd(input logic [3:0] q, output logic hit, output logic [15:0] data);
    hit = 1'b0; data = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      if (!hit && active(m[k]) && m[k].wa == q) begin
        hit = 1'b1; data = value(m[k]);
      end
    end
  endtask

  initial begin
    logic h;
    logic [15:0] d;
    ent_t ne;

    tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,4'd5,4'd5,4'd6,16'h1234,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b1,16'h1234, 1'b0,16'h0000};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,4'd6,4'd5,4'd6,16'h0000,16'hBEEF, 1'b0,1'b0,4'd0,16'h0000, 1'b1,16'h1234, 1'b1,16'hBEEF};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,4'd7,4'd7,4'd5,16'h00BB,16'h0000, 1'b1,1'b1,4'd5,16'h1234, 1'b1,16'h00BB, 1'b1,16'h1234};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,4'd0,4'd7,4'd0,16'h0011,16'h0000, 1'b1,1'b1,4'd6,16'hBEEF, 1'b1,16'h00BB, 1'b0,16'h0000};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,4'd7,4'd7,4'd0,16'h00AA,16'h0000, 1'b1,1'b1,4'd7,16'h00BB, 1'b1,16'h00AA, 1'b0,16'h0000};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,4'd9,4'd7,4'd9,16'hFFFF,16'hFFFF, 1'b1,1'b1,4'd7,16'h00BB, 1'b1,16'h00AA, 1'b0,16'h0000};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,4'd9,4'd7,4'd5,16'hFFFF,16'hFFFF, 1'b1,1'b1,4'd7,16'h00BB, 1'b1,16'h00AA, 1'b0,16'h0000};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,4'd9,4'd7,4'd0,16'hFFFF,16'hFFFF, 1'b0,1'b0,4'd7,16'h00BB, 1'b0,16'h0000, 1'b0,16'h0000};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,4'd3,4'd3,4'd7,16'h0033,16'h0000, 1'b0,1'b0,4'd0,16'h0011, 1'b0,16'h0000, 1'b0,16'h0000};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,4'd0,4'd3,4'd0,16'h0044,16'h0000, 1'b0,1'b0,4'd7,16'h00AA, 1'b0,16'h0000, 1'b0,16'h0000};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd3,4'd0,16'h0000,16'h0000, 1'b0,1'b0,4'd3,16'h0033, 1'b0,16'h0000, 1'b0,16'h0000};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd3,16'h0000,16'h0000, 1'b1,1'b0,4'd0,16'h0044, 1'b0,16'h0000, 1'b0,16'h0000};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd3,16'h0000,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset_wb_data", {16'd0, wb_data_out}, 32'd0);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].v, tbl[i].we, tbl[i].m2r, tbl[i].wa,
            tbl[i].alu, tbl[i].mem, tbl[i].rs, tbl[i].rt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid_out", i), {31'd0, valid_out}, {31'd0, tbl[i].e_vo});
      chk($sformatf("vec%0d_WriteEn_out", i), {31'd0, WriteEn_out}, {31'd0, tbl[i].e_we});
      chk($sformatf("vec%0d_waddr_out", i), {28'd0, waddr_out}, {28'd0, tbl[i].e_wa});
      chk($sformatf("vec%0d_wb_data", i), {16'd0, wb_data_out}, {16'd0, tbl[i].e_wb});
      chk($sformatf("vec%0d_rs_hit", i), {31'd0, fwd_rs_hit}, {31'd0, tbl[i].e_rsh});
      chk($sformatf("vec%0d_rs_data", i), {16'd0, fwd_rs_data}, {16'd0, tbl[i].e_rsd});
      chk($sformatf("vec%0d_rt_hit", i), {31'd0, fwd_rt_hit}, {31'd0, tbl[i].e_rth});
      chk($sformatf("vec%0d_rt_data", i), {16'd0, fwd_rt_data}, {16'd0, tbl[i].e_rtd});
    end

    // Asynchronous reset mid-stream with valid entries in flight
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, i[3:0], 16'h0101 * i[15:0], 16'h0000, 4'd3, 4'd2);
      @(posedge clk); #1;
    end
    chk("prereset_valid_out", {31'd0, valid_out}, 32'd1);
    chk("prereset_rs_hit", {31'd0, fwd_rs_hit}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("async_rst_WriteEn_out", {31'd0, WriteEn_out}, 32'd0);
    chk("async_rst_waddr_out", {28'd0, waddr_out}, 32'd0);
    chk("async_rst_alu_out", {16'd0, alu_result_out}, 32'd0);
    chk("async_rst_wb_data", {16'd0, wb_data_out}, 32'd0);
    chk("async_rst_rs_hit", {31'd0, fwd_rs_hit}, 32'd0);
    chk("async_rst_rt_hit", {31'd0, fwd_rt_hit}, 32'd0);
    chk("async_rst_rt_data", {16'd0, fwd_rt_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd1, 4'd2);
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("post_rst_WriteEn_out", {31'd0, WriteEn_out}, 32'd0);
    end
    // The two idle edges left the list as {idle, idle, cleared}; after one more idle edge all are idle.
    @(posedge clk); #1;

    // Randomized run against an ordered list of in-flight entries (index 0 = youngest).
    for (int k = 0; k < 3; k++) m[k] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      ne = '{valid_in, WriteEn_in, memToReg_in, waddr_in, alu_result_in, mem_data_in};
      @(posedge clk);
      if (flush) begin
        for (int k = 0; k < 3; k++) begin m[k].v = 1'b0; m[k].we = 1'b0; end
      end else if (!stall) begin
        m[2] = m[1]; m[1] = m[0]; m[0] = ne;
      end
      #1;
      chk("rnd_valid_out", {31'd0, valid_out}, {31'd0, m[2].v});
      chk("rnd_WriteEn_out", {31'd0, WriteEn_out}, {31'd0, active(m[2])});
      chk("rnd_waddr_out", {28'd0, waddr_out}, {28'd0, m[2].wa});
      chk("rnd_alu_out", {16'd0, alu_result_out}, {16'd0, m[2].alu});
      chk("rnd_mem_out", {16'd0, mem_data_out}, {16'd0, m[2].mem});
      chk("rnd_m2r_out", {31'd0, memToReg_out}, {31'd0, m[2].m2r});
      chk("rnd_wb_data", {16'd0, wb_data_out}, {16'd0, value(m[2])});
      model_fwd(rs_addr, h, d);
      chk("rnd_rs_hit", {31'd0, fwd_rs_hit}, {31'd0, h});
      chk("rnd_rs_data", {16'd0, fwd_rs_data}, {16'd0, d});
      model_fwd(rt_addr, h, d);
      chk("rnd_rt_hit", {31'd0, fwd_rt_hit}, {31'd0, h});
      chk("rnd_rt_data", {16'd0, fwd_rt_data}, {16'd0, d});
    end

`ifdef MEM_WB_PERF_EN
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("perf_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("perf_rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    chk("perf_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    chk("perf_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    flush = 1'b0; stall = 1'b1;
    repeat (65532) @(posedge clk);
    #1;
    chk("perf_stall_max", {16'd0, stall_cnt}, 32'h0000FFFF);
    @(posedge clk); #1;
    chk("perf_stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    stall = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
